// File: rtl/uart_rx_module_if.sv
// Bus interface for uart_rx_module.
//   rx            serial line, idle high, asynchronous to the receiver clock
//   parity        1 = odd parity, 0 = even parity
//   speed         bit period in clock cycles (values below 2 behave as 2)
//   data          last received 9-bit word, LSB first on the line
//   data_valid    one-cycle pulse when data and error flags update
//   parity_error  parity mismatch on the last frame
//   framing_error stop bit sampled low on the last frame
//   busy          receiver is inside a frame
interface uart_rx_module_if;
  logic       rx;
  logic       parity;
  logic [3:0] speed;
  logic [8:0] data;
  logic       data_valid;
  logic       parity_error;
  logic       framing_error;
  logic       busy;

  // Line side / configuration source.
  modport master (
    output rx, parity, speed,
    input  data, data_valid, parity_error, framing_error, busy
  );

  // Receiver side.
  modport slave (
    input  rx, parity, speed,
    output data, data_valid, parity_error, framing_error, busy
  );
endinterface

// File: rtl/uart_rx_module.sv
// UART receiver: start bit, 9 data bits (LSB first), parity bit, stop bit.
// Ports:
//   clk  sole clock, rising edge
//   rst  asynchronous active-high reset
//   bus  uart_rx_module_if.slave (rx/parity/speed in; data, flags, busy out)
module uart_rx_module (
  input logic              clk,
  input logic              rst,
  uart_rx_module_if.slave  bus
);

  typedef enum logic [2:0] {StIdle, StStart, StData, StPar, StStop} state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] bit_idx_q, bit_idx_d;
  logic [8:0] shift_q, shift_d;
  logic       par_q, par_d;
  logic [3:0] period_q, period_d;
  logic       mode_q, mode_d;
  logic       load;

  logic       rx_meta, rxs, rxs_prev;
  logic       fall;
  logic [3:0] half_m1, period_m1;

  logic [8:0] data_q;
  logic       parity_error_q, framing_error_q, data_valid_q;

  // Two-flop synchronizer plus one history flop for edge detection. All flops
  // reset high so a released reset never looks like the line going idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta  <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      rx_meta  <= bus.rx;
      rxs      <= rx_meta;
      rxs_prev <= rxs;
    end
  end

  // Only a 1->0 transition arms the receiver; a line stuck low never does.
  assign fall      = rxs_prev & ~rxs;
  assign half_m1   = (period_q >> 1) - 4'd1;
  assign period_m1 = period_q - 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      bit_idx_q <= 4'd0;
      shift_q   <= 9'd0;
      par_q     <= 1'b0;
      period_q  <= 4'd2;
      mode_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      period_q  <= period_d;
      mode_q    <= mode_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 4'd1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_d     = par_q;
    period_d  = period_q;
    mode_d    = mode_q;
    load      = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = 4'd0;
        if (fall) begin
          state_d  = StStart;
          // Speed and parity mode are frozen for the whole frame.
          period_d = (bus.speed < 4'd2) ? 4'd2 : bus.speed;
          mode_d   = bus.parity;
        end
      end
      StStart: begin
        // Re-check the line mid-way through the start bit to reject glitches.
        if (cnt_q == half_m1) begin
          cnt_d     = 4'd0;
          bit_idx_d = 4'd0;
          state_d   = rxs ? StIdle : StData;
        end
      end
      StData: begin
        if (cnt_q == period_m1) begin
          cnt_d     = 4'd0;
          // Shift right so the first sample lands in bit 0 after nine shifts.
          shift_d   = {rxs, shift_q[8:1]};
          bit_idx_d = bit_idx_q + 4'd1;
          if (bit_idx_q == 4'd8) state_d = StPar;
        end
      end
      StPar: begin
        if (cnt_q == period_m1) begin
          cnt_d   = 4'd0;
          par_d   = rxs;
          state_d = StStop;
        end
      end
      StStop: begin
        if (cnt_q == period_m1) begin
          cnt_d   = 4'd0;
          load    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Result registers hold until the next completed frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q          <= 9'd0;
      parity_error_q  <= 1'b0;
      framing_error_q <= 1'b0;
      data_valid_q    <= 1'b0;
    end else begin
      data_valid_q <= load;
      if (load) begin
        data_q          <= shift_q;
        // XOR of data and parity bit is 1 when the total ones count is odd.
        parity_error_q  <= (^shift_q ^ par_q) != mode_q;
        framing_error_q <= ~rxs;
      end
    end
  end

  assign bus.data          = data_q;
  assign bus.data_valid    = data_valid_q;
  assign bus.parity_error  = parity_error_q;
  assign bus.framing_error = framing_error_q;
  assign bus.busy          = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_module.sv
module tb_uart_rx_module;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  uart_rx_module_if u();

  uart_rx_module dut (
    .clk (clk),
    .rst (rst),
    .bus (u.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observation of output pulses, sampled on the falling edge.
  int         dv_count;
  int         busy_count;
  logic [8:0] last_data;
  logic       last_pe;
  logic       last_fe;
  logic       last_busy;

  initial begin
    dv_count   = 0;
    busy_count = 0;
    last_data  = '0;
    last_pe    = 1'b0;
    last_fe    = 1'b0;
    last_busy  = 1'b0;
  end

  always @(negedge clk) begin
    if (u.busy === 1'b1) busy_count = busy_count + 1;
    if (u.data_valid === 1'b1) begin
      dv_count  = dv_count + 1;
      last_data = u.data;
      last_pe   = u.parity_error;
      last_fe   = u.framing_error;
      last_busy = u.busy;
    end
  end

  // Reference model: frame rules expressed as plain arithmetic.
  function automatic int eff_period(input logic [3:0] s);
    return (s < 2) ? 2 : int'(s);
  endfunction

  function automatic int ones_of(input logic [8:0] d);
    int n = 0;
    for (int i = 0; i < 9; i++) n += int'(d[i]);
    return n;
  endfunction

  // Parity bit that makes the frame legal for the given mode.
  function automatic logic good_pbit(input logic [8:0] d, input logic mode);
    return ((ones_of(d) % 2) == (mode ? 1 : 0)) ? 1'b0 : 1'b1;
  endfunction

  function automatic logic exp_pe(input logic [8:0] d, input logic pb, input logic mode);
    return (((ones_of(d) + int'(pb)) % 2) != (mode ? 1 : 0));
  endfunction

  // Drive one whole frame at the given period. At line bit chg_bit (0 = start)
  // the speed input is rewritten to chg_speed; pass chg_bit < 0 for none.
  task automatic send_frame(input logic [8:0] d, input logic pb, input logic sb,
                            input int period, input int chg_bit,
                            input logic [3:0] chg_speed);
    logic [11:0] bits;
    bits = {sb, pb, d, 1'b0};
    for (int i = 0; i < 12; i++) begin
      if (i == chg_bit) u.speed = chg_speed;
      u.rx = bits[i];
      repeat (period) @(negedge clk);
    end
    u.rx = 1'b1;
  endtask

  task automatic wait_dv(input int target);
    for (int i = 0; i < 200 && dv_count < target; i++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    u.rx = 1'b1;
    u.parity = 1'b0;
    u.speed = 4'd2;
    repeat (3) @(negedge clk);
    tests_run++;
    if (u.data !== 9'd0) begin
      tests_failed++; $display("FAIL reset_data got %h want 000", u.data);
    end
    tests_run++;
    if (u.data_valid !== 1'b0 || u.busy !== 1'b0) begin
      tests_failed++; $display("FAIL reset_dv_busy got %b%b want 00", u.data_valid, u.busy);
    end
    tests_run++;
    if (u.parity_error !== 1'b0 || u.framing_error !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_flags got %b%b want 00", u.parity_error, u.framing_error);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic_odd;
    int base = dv_count;
    u.speed = 4'd2; u.parity = 1'b1;
    send_frame(9'b100101110, 1'b0, 1'b1, 2, -1, 4'd0);
    wait_dv(base + 1);
    tests_run++;
    if (dv_count !== base + 1) begin
      tests_failed++; $display("FAIL odd_dv_count got %0d want %0d", dv_count, base + 1);
    end
    tests_run++;
    if (last_data !== 9'h12E || last_pe !== 1'b0 || last_fe !== 1'b0) begin
      tests_failed++;
      $display("FAIL odd_frame got %h pe%b fe%b want 12e pe0 fe0", last_data, last_pe, last_fe);
    end
    tests_run++;
    if (last_busy !== 1'b0) begin
      tests_failed++; $display("FAIL busy_at_dv got %b want 0", last_busy);
    end
  endtask

  task automatic test_even_parity;
    int base = dv_count;
    u.speed = 4'd3; u.parity = 1'b0;
    send_frame(9'b101010110, 1'b1, 1'b1, 3, -1, 4'd0);
    wait_dv(base + 1);
    tests_run++;
    if (dv_count !== base + 1 || last_data !== 9'h156 || last_pe !== 1'b0) begin
      tests_failed++;
      $display("FAIL even_good got n%0d %h pe%b want n%0d 156 pe0", dv_count, last_data,
               last_pe, base + 1);
    end
    send_frame(9'b101010110, 1'b0, 1'b1, 3, -1, 4'd0);
    wait_dv(base + 2);
    tests_run++;
    if (dv_count !== base + 2 || last_data !== 9'h156 || last_pe !== 1'b1) begin
      tests_failed++;
      $display("FAIL even_bad got n%0d %h pe%b want n%0d 156 pe1", dv_count, last_data,
               last_pe, base + 2);
    end
  endtask

  task automatic test_framing;
    int base = dv_count;
    u.speed = 4'd4; u.parity = 1'b1;
    send_frame(9'h0A5, good_pbit(9'h0A5, 1'b1), 1'b0, 4, -1, 4'd0);
    u.rx = 1'b0;
    repeat (60) @(negedge clk);
    tests_run++;
    if (dv_count !== base + 1 || last_fe !== 1'b1 || last_data !== 9'h0A5) begin
      tests_failed++;
      $display("FAIL framing got n%0d fe%b %h want n%0d fe1 0a5", dv_count, last_fe,
               last_data, base + 1);
    end
    tests_run++;
    if (u.busy !== 1'b0) begin
      tests_failed++; $display("FAIL low_line_busy got %b want 0", u.busy);
    end
    u.rx = 1'b1;
    repeat (4) @(negedge clk);
    send_frame(9'h133, good_pbit(9'h133, 1'b1), 1'b1, 4, -1, 4'd0);
    wait_dv(base + 2);
    tests_run++;
    if (dv_count !== base + 2 || last_data !== 9'h133 || last_fe !== 1'b0 || last_pe !== 1'b0)
    begin
      tests_failed++;
      $display("FAIL rearm got n%0d %h fe%b pe%b want n%0d 133 fe0 pe0", dv_count, last_data,
               last_fe, last_pe, base + 2);
    end
  endtask

  task automatic test_false_start;
    int base = dv_count;
    int bbase = busy_count;
    u.speed = 4'd4;
    u.rx = 1'b0;
    @(negedge clk);
    u.rx = 1'b1;
    repeat (12) @(negedge clk);
    tests_run++;
    if (busy_count == bbase) begin
      tests_failed++; $display("FAIL false_start_busy got never-high want high-then-low");
    end
    tests_run++;
    if (u.busy !== 1'b0 || dv_count !== base) begin
      tests_failed++;
      $display("FAIL false_start got busy%b n%0d want busy0 n%0d", u.busy, dv_count, base);
    end
  endtask

  task automatic test_reset_mid;
    int base = dv_count;
    u.speed = 4'd2; u.parity = 1'b1;
    u.rx = 1'b0; repeat (2) @(negedge clk);        // start
    repeat (8) @(negedge clk);                     // data bits 0..3 = 0
    u.rx = 1'b1; @(negedge clk);                   // inside data bit 4
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if (u.data !== 9'd0 || u.busy !== 1'b0 || u.parity_error !== 1'b0 ||
        u.framing_error !== 1'b0 || u.data_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset got %h b%b pe%b fe%b dv%b want 000 all 0", u.data, u.busy,
               u.parity_error, u.framing_error, u.data_valid);
    end
    rst = 1'b0;
    repeat (30) @(negedge clk);
    tests_run++;
    if (dv_count !== base || u.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL abandoned got n%0d busy%b want n%0d busy0", dv_count, u.busy, base);
    end
    send_frame(9'h0FF, good_pbit(9'h0FF, 1'b1), 1'b1, 2, -1, 4'd0);
    wait_dv(base + 1);
    tests_run++;
    if (dv_count !== base + 1 || last_data !== 9'h0FF || last_pe !== 1'b0) begin
      tests_failed++;
      $display("FAIL after_reset got n%0d %h pe%b want n%0d 0ff pe0", dv_count, last_data,
               last_pe, base + 1);
    end
  endtask

  task automatic test_speed;
    logic [8:0] d;
    for (int s = 0; s < 2; s++) begin
      int base = dv_count;
      d = 9'($urandom_range(0, 511));
      u.speed = 4'(s); u.parity = 1'b0;
      send_frame(d, good_pbit(d, 1'b0), 1'b1, 2, -1, 4'd0);
      wait_dv(base + 1);
      tests_run++;
      if (dv_count !== base + 1 || last_data !== d || last_pe !== 1'b0) begin
        tests_failed++;
        $display("FAIL low_speed%0d got n%0d %h pe%b want n%0d %h pe0", s, dv_count,
                 last_data, last_pe, base + 1, d);
      end
    end
    begin
      int base = dv_count;
      d = 9'($urandom_range(0, 511));
      u.speed = 4'd2; u.parity = 1'b1;
      send_frame(d, good_pbit(d, 1'b1), 1'b1, 2, 4, 4'd3);
      wait_dv(base + 1);
      tests_run++;
      if (dv_count !== base + 1 || last_data !== d || last_pe !== 1'b0) begin
        tests_failed++;
        $display("FAIL speed_change got n%0d %h pe%b want n%0d %h pe0", dv_count, last_data,
                 last_pe, base + 1, d);
      end
    end
  endtask

  task automatic test_random;
    logic [8:0] d;
    logic       mode, pb, sb;
    logic [3:0] s;
    for (int k = 0; k < 20; k++) begin
      int base = dv_count;
      d    = 9'($urandom_range(0, 511));
      mode = 1'($urandom_range(0, 1));
      s    = 4'($urandom_range(0, 15));
      pb   = ($urandom_range(0, 3) == 0) ? ~good_pbit(d, mode) : good_pbit(d, mode);
      sb   = ($urandom_range(0, 4) != 0);
      u.speed = s; u.parity = mode;
      send_frame(d, pb, sb, eff_period(s), -1, 4'd0);
      wait_dv(base + 1);
      tests_run++;
      if (dv_count !== base + 1 || last_data !== d || last_pe !== exp_pe(d, pb, mode) ||
          last_fe !== ~sb) begin
        tests_failed++;
        $display("FAIL random%0d s%0d got n%0d %h pe%b fe%b want n%0d %h pe%b fe%b", k, s,
                 dv_count, last_data, last_pe, last_fe, base + 1, d, exp_pe(d, pb, mode), ~sb);
      end
      repeat (3) @(negedge clk);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b1;
    u.rx = 1'b1;
    u.parity = 1'b0;
    u.speed = 4'd2;
    @(negedge clk);
    test_reset();
    test_basic_odd();
    test_even_parity();
    test_framing();
    test_false_start();
    test_reset_mid();
    test_speed();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_rx_module.md
UART_RX_MODULE -- requirements
Module: uart_rx_module

Interface
REQ-001 SHALL have port: Clock  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have port: Reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: Rx  input  1  serial line, idle high, asynchronous to Clock.
REQ-004 SHALL have port: Parity  input  1  1 = odd parity, 0 = even parity.
REQ-005 SHALL have port: Speed  input  4  bit period in Clock cycles.
REQ-006 SHALL have port: Data  output  9  last received word, LSB first on line.
REQ-007 SHALL have port: DataValid  output  1  one-cycle pulse, Data/error flags updated.
REQ-008 SHALL have port: ParityError  output  1  parity mismatch on last frame.
REQ-009 SHALL have port: FramingError  output  1  stop bit sampled 0 on last frame.
REQ-010 SHALL have port: Busy  output  1  high whenever state is not IDLE.

Function
REQ-011 Frame SHALL be: start bit (0), Data[0]..Data[8], parity bit, stop bit (1), each lasting one bit period.
REQ-012 Rx SHALL pass through a 2-flop synchronizer; all logic SHALL use the synchronized value (rxs).
REQ-013 Effective period P SHALL be max(Speed, 2), latched at start detection; Speed changes mid-frame SHALL have no effect.
REQ-014 States SHALL be IDLE, START, DATA, PAR, STOP.
REQ-015 IDLE -> START SHALL occur on a falling edge of rxs (previous 1, current 0); a constant low line SHALL NOT start a frame.
REQ-016 START SHALL sample rxs when cycle counter reaches floor(P/2)-1; sample 1 -> IDLE (false start, no DataValid); sample 0 -> DATA with counter cleared.
REQ-017 DATA, PAR, STOP SHALL each sample rxs when counter reaches P-1 (one full period after previous sample), then clear counter.
REQ-018 DATA SHALL shift nine samples into a 9-bit register, first sample into bit 0; after the ninth -> PAR.
REQ-019 PAR SHALL compute expected bit: odd mode makes total ones in 9 data bits + parity bit odd; even mode makes it even.
REQ-020 At STOP sample, next cycle SHALL: load Data, set ParityError, set FramingError = ~stop sample, pulse DataValid for exactly one cycle, return to IDLE.
REQ-021 Data, ParityError, FramingError SHALL hold until the next DataValid; errors SHALL NOT suppress DataValid.
REQ-022 After a framing error, IDLE SHALL NOT re-arm until rxs has been 1 for at least one cycle (falling-edge rule of REQ-015).
REQ-023 Parity input SHALL be latched at start detection together with Speed.
REQ-024 Busy SHALL go high the cycle after start detection and low in the DataValid cycle.

Reset
REQ-025 Reset asserted SHALL immediately force IDLE, counters 0, synchronizer flops 1, Data = 0, DataValid = 0, ParityError = 0, FramingError = 0, Busy = 0.
REQ-026 Reset mid-frame SHALL abandon the frame with no DataValid; reception restarts only on a new falling edge after release.

Verification
REQ-027 Speed=2, Parity=1, frame of 9'b100101110 with parity bit 0, stop 1 -> one DataValid pulse, Data=9'h12E, ParityError=0, FramingError=0.
REQ-028 Speed=3, Parity=0, frame of 9'b101010110 with parity bit 1 -> Data=9'h156, ParityError=0; same frame with parity bit 0 -> ParityError=1, DataValid still pulses.
REQ-029 Speed=4, frame with stop bit 0 -> FramingError=1; line held low afterwards -> no further DataValid until line returns high then falls.
REQ-030 Speed=4, Rx low for 1 cycle then high -> false start, Busy returns low, no DataValid.
REQ-031 Reset pulsed at data bit 4 of a Speed=2 frame -> all outputs 0, no DataValid; subsequent clean frame 9'h0FF received correctly.
REQ-032 Speed=0 and Speed=1 -> behave as Speed=2; Speed changed from 2 to 3 mid-frame -> frame received at period 2, Data correct.
